// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_OCC_W = 2;

    // Default field widths for each stage boundary of the core.
    localparam int IFID_CTRL_W  = 4;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 96;
    localparam int MEMWB_CTRL_W = 4;
    localparam int MEMWB_DATA_W = 64;

    // An all-zero control word decodes as a NOP downstream.
    localparam int NOP_CTRL = 0;

    function automatic logic [PIPE_OCC_W-1:0] occOf(input pipe_state_e s);
        return PIPE_OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage entry (valid, ctrl, data). clear beats load; a cleared
// entry always carries the NOP control word, data is zeroed only with CLEAR_DATA.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 64,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ldCtrl,
    input  logic [DATA_W-1:0] ldData,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: non-blocking assignments for all state; the data register is reset
    // too, so a bubble never exposes stale X payload after power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(NOP_CTRL);
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(NOP_CTRL);
            if (CLEAR_DATA) data <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ldCtrl;
            data  <= ldData;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush.
// Define PIPE_STAGE_SKID_EN to add a skid slot and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 64,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    logic              headValid, headLoad, headClear;
    logic [CTRL_W-1:0] headCtrl, headLdCtrl;
    logic [DATA_W-1:0] headData, headLdData;
    logic              inXfer, outXfer;

    assign inXfer    = in_valid & in_ready;
    assign outXfer   = headValid & out_ready;
    assign out_valid = headValid;
    assign out_ctrl  = headCtrl;
    assign out_data  = headData;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) headSlot (
        .clk(clk), .rst(rst), .load(headLoad), .clear(headClear),
        .ldCtrl(headLdCtrl), .ldData(headLdData),
        .valid(headValid), .ctrl(headCtrl), .data(headData)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic              skidValid, skidLoad, skidClear;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;
    pipe_state_e       state, nextState;
    logic              inReadyQ;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) skidSlot (
        .clk(clk), .rst(rst), .load(skidLoad), .clear(skidClear),
        .ldCtrl(in_ctrl), .ldData(in_data),
        .valid(skidValid), .ctrl(skidCtrl), .data(skidData)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        headLoad   = 1'b0;
        headClear  = 1'b0;
        skidLoad   = 1'b0;
        skidClear  = 1'b0;
        nextState  = state;
        headLdCtrl = skidValid ? skidCtrl : in_ctrl;
        headLdData = skidValid ? skidData : in_data;
        if (flush) begin
            headClear = 1'b1;
            skidClear = 1'b1;
            nextState = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (inXfer) begin
                    headLoad  = 1'b1;
                    nextState = ONE;
                end
                ONE: begin
                    if (inXfer && outXfer) begin
                        headLoad = 1'b1;
                    end else if (inXfer) begin
                        skidLoad  = 1'b1;
                        nextState = TWO;
                    end else if (outXfer) begin
                        headClear = 1'b1;
                        nextState = EMPTY;
                    end
                end
                TWO: if (outXfer) begin
                    headLoad  = 1'b1;
                    skidClear = 1'b1;
                    nextState = ONE;
                end
                default: nextState = EMPTY;
            endcase
        end
    end

    // in_ready comes straight from a flop, cutting the path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
        end else begin
            state    <= nextState;
            inReadyQ <= (nextState != TWO);
        end
    end

    assign in_ready  = inReadyQ;
    assign occupancy = occOf(state);
`else
    assign in_ready = !headValid | out_ready;

    always_comb begin
        headLdCtrl = in_ctrl;
        headLdData = in_data;
        headLoad   = inXfer & !flush;
        headClear  = flush | (outXfer & !inXfer);
    end

    assign occupancy = {1'b0, headValid};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard-checked bench for pipe_stage_reg; covers both the
// base and the PIPE_STAGE_SKID_EN build, and both CLEAR_DATA settings.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [7:0]  out_ctrl;
    logic [63:0] out_data;
    logic [1:0]  occupancy;

    logic        in_ready1, out_valid1;
    logic [7:0]  out_ctrl1;
    logic [63:0] out_data1;
    logic [1:0]  occupancy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .CLEAR_DATA(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .occupancy(occupancy)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .CLEAR_DATA(1'b1)) dutClr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occupancy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    typedef struct {
        logic [7:0]  c;
        logic [63:0] d;
    } ent_t;

    initial begin
        ent_t        q[$];
        logic        holdPrev;
        logic [7:0]  prevCtrl;
        logic [63:0] prevData;
        logic        expIr;

        // Reset state
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ctrl", out_ctrl, 8'h00);
        check("rst_data", out_data, 64'h0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_inready", in_ready, 1'b1);
        rst = 1'b0;

        // 1: back-to-back stream, one cycle latency, occupancy stays 1
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(i), 64'hA000_0000_0000_0000 | 64'(i));
            tick();
            check("s1_valid", out_valid, 1'b1);
            check("s1_ctrl", out_ctrl, 64'(i));
            check("s1_data", out_data, 64'hA000_0000_0000_0000 | 64'(i));
            check("s1_occ", occupancy, 2'd1);
        end
        drive(1'b0, 8'h00, 64'h0);
        tick();
        check("s1_drain_valid", out_valid, 1'b0);
        check("s1_drain_ctrl", out_ctrl, 8'h00);
        check("s1_drain_data_keep", out_data, 64'hA000_0000_0000_000A);
        check("s1_drain_data_clr", out_data1, 64'h0);
        check("s1_drain_occ", occupancy, 2'd0);

        // 2: downstream stall for 3 cycles with 0x11 then 0x22
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 64'hD11);
        tick();
        check("s2_first", out_ctrl, 8'h11);
        drive(1'b1, 8'h22, 64'hD22);
        #1;
        check("s2_inready_stalled", in_ready, SKID ? 64'd1 : 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s2_hold_valid", out_valid, 1'b1);
            check("s2_hold_ctrl", out_ctrl, 8'h11);
            check("s2_hold_data", out_data, 64'hD11);
            check("s2_hold_occ", occupancy, SKID ? 64'd2 : 64'd1);
            check("s2_hold_inready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check("s2_rel_ctrl", out_ctrl, 8'h22);
        check("s2_rel_data", out_data, 64'hD22);
        check("s2_rel_occ", occupancy, 2'd1);
        check("s2_rel_inready", in_ready, 1'b1);
        drive(1'b0, 8'h00, 64'h0);
        tick();
        check("s2_end_valid", out_valid, 1'b0);

        // 3: flush while full (skid: two held) with 0x33 offered
        out_ready = 1'b0;
        drive(1'b1, 8'h44, 64'hD44);
        tick();
        drive(1'b1, 8'h55, 64'hD55);
        tick();
        check("s3_full_occ", occupancy, SKID ? 64'd2 : 64'd1);
        check("s3_full_ctrl", out_ctrl, 8'h44);
        flush = 1'b1;
        drive(1'b1, 8'h33, 64'hD33);
        #1;
        check("s3_inready_flush", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        check("s3_valid", out_valid, 1'b0);
        check("s3_ctrl", out_ctrl, 8'h00);
        check("s3_occ", occupancy, 2'd0);
        check("s3_data_keep", out_data, 64'hD44);
        check("s3_data_clr", out_data1, 64'h0);
        check("s3_ctrl_clr", out_ctrl1, 8'h00);
        drive(1'b0, 8'h00, 64'h0);
        tick();
        check("s3_no33_valid", out_valid, 1'b0);
        check("s3_no33_ctrl", out_ctrl, 8'h00);
        check("s3_inready", in_ready, 1'b1);

        // 4: single entry then drain
        out_ready = 1'b1;
        drive(1'b1, 8'h66, 64'hD66);
        tick();
        check("s4_ctrl", out_ctrl, 8'h66);
        drive(1'b0, 8'h00, 64'h0);
        tick();
        check("s4_valid", out_valid, 1'b0);
        check("s4_ctrl0", out_ctrl, 8'h00);
        check("s4_data_keep", out_data, 64'hD66);
        check("s4_data_clr", out_data1, 64'h0);
        check("s4_valid_clr", out_valid1, 1'b0);

        // 5: asynchronous reset between edges while full
        out_ready = 1'b0;
        drive(1'b1, 8'h77, 64'hD77);
        tick();
        check("s5_full", out_valid, 1'b1);
        drive(1'b0, 8'h00, 64'h0);
        #2;
        rst = 1'b1;
        #1;
        check("s5_async_valid", out_valid, 1'b0);
        check("s5_async_ctrl", out_ctrl, 8'h00);
        check("s5_async_data", out_data, 64'h0);
        check("s5_async_occ", occupancy, 2'd0);
        check("s5_async_data_clr", out_data1, 64'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'h78, 64'hD78);
        tick();
        check("s5_after_ctrl", out_ctrl, 8'h78);
        check("s5_after_data", out_data, 64'hD78);
        drive(1'b0, 8'h00, 64'h0);
        tick();
        check("s5_after_drain", out_valid, 1'b0);

        // 6: random traffic with occasional flush against a queue model
        holdPrev = 1'b0;
        prevCtrl = '0;
        prevData = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_ctrl   = 8'($urandom_range(1, 255));
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 5);
            #1;
            expIr = SKID ? (q.size() != 2) : (q.size() == 0 || out_ready);
            check("r_valid", out_valid, q.size() != 0);
            check("r_occ", occupancy, 64'(q.size()));
            check("r_inready", in_ready, expIr);
            check("r_ctrl", out_ctrl, (q.size() != 0) ? 64'(q[0].c) : 64'h0);
            check("r_ctrl_clr", out_ctrl1, (q.size() != 0) ? 64'(q[0].c) : 64'h0);
            if (q.size() != 0) check("r_data", out_data, q[0].d);
            if (holdPrev) begin
                check("r_stable_ctrl", out_ctrl, prevCtrl);
                check("r_stable_data", out_data, prevData);
            end
            holdPrev = (q.size() != 0) && !out_ready && !flush;
            prevCtrl = out_ctrl;
            prevData = out_data;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && expIr) q.push_back('{c: in_ctrl, d: in_data});
            end
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 8'h00, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
